// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, RUN/HALTED control.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [7:0]         RESET_PC = 8'h00,
    parameter int                 INSTR_W  = 8,
    parameter logic [INSTR_W-1:0] NOP      = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [7:0]         pc_out,
    input  logic [7:0]         pc_plus1,
    output logic [7:0]         imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [7:0]         branch_target,
    input  logic               halt_req,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [7:0]         ifid_pc,
    output logic [7:0]         ifid_pc_plus1,
    output logic               ifid_valid,
    output logic               halted,
    output logic [15:0]        fetch_count,
    output logic [15:0]        bubble_count
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t     state;
    logic [7:0] pc;

    assign pc_out    = pc;
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    // Priority in RUN: halt_req > branch_taken > stall > normal fetch.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            ifid_instr    <= NOP;
            ifid_pc       <= 8'h00;
            ifid_pc_plus1 <= 8'h00;
            ifid_valid    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req || branch_taken) begin
                        if (halt_req) state <= HALTED;
                        else          pc    <= branch_target;
                        ifid_instr    <= NOP;
                        ifid_pc       <= 8'h00;
                        ifid_pc_plus1 <= 8'h00;
                        ifid_valid    <= 1'b0;
                    end else if (!stall) begin
                        pc            <= pc_plus1;
                        ifid_instr    <= imem_rdata;
                        ifid_pc       <= pc;
                        ifid_pc_plus1 <= pc_plus1;
                        ifid_valid    <= 1'b1;
                    end
                end
                HALTED: ;
                default: state <= RUN;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic load_valid;
    logic load_bubble;

    assign load_bubble = (state == RUN) && (halt_req || branch_taken);
    assign load_valid  = (state == RUN) && !halt_req && !branch_taken && !stall;

    // Saturating counters; they stick at 16'hFFFF rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count  <= 16'h0000;
            bubble_count <= 16'h0000;
        end else begin
            if (load_valid && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
            if (load_bubble && bubble_count != 16'hFFFF)
                bubble_count <= bubble_count + 16'd1;
        end
    end
`else
    assign fetch_count  = 16'h0000;
    assign bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver pushes model predictions, monitor pops and compares.
module tb_fetch_stage;

    localparam int                 INSTR_W  = 8;
    localparam logic [7:0]         RESET_PC = 8'h00;
    localparam logic [INSTR_W-1:0] NOP      = '0;

    logic               clk;
    logic               rst;
    logic [7:0]         pc_out;
    logic [7:0]         pc_plus1;
    logic [7:0]         imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               branch_taken;
    logic [7:0]         branch_target;
    logic               halt_req;
    logic [INSTR_W-1:0] ifid_instr;
    logic [7:0]         ifid_pc;
    logic [7:0]         ifid_pc_plus1;
    logic               ifid_valid;
    logic               halted;
    logic [15:0]        fetch_count;
    logic [15:0]        bubble_count;

    logic [INSTR_W-1:0] mem [256];

    // External incrementer and combinational-read instruction memory.
    assign pc_plus1   = pc_out + 8'd1;
    assign imem_rdata = mem[imem_addr];

    fetch_stage #(.RESET_PC(RESET_PC), .INSTR_W(INSTR_W), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .pc_plus1(pc_plus1),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]         pc;
        logic [INSTR_W-1:0] instr;
        logic [7:0]         ipc;
        logic [7:0]         ipc1;
        logic               valid;
        logic               halted;
        logic [15:0]        fcnt;
        logic [15:0]        bcnt;
    } exp_t;

    exp_t sbq[$];
    exp_t m;
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: next architectural state from the current one plus this cycle's requests.
    function automatic void model_step(input logic r, input logic s, input logic b,
                                       input logic [7:0] t, input logic h);
        if (r) begin
            m.pc = RESET_PC; m.instr = NOP; m.ipc = 8'h00; m.ipc1 = 8'h00;
            m.valid = 1'b0; m.halted = 1'b0; m.fcnt = 16'h0; m.bcnt = 16'h0;
        end else if (m.halted) begin
            // frozen until reset
        end else if (h || b) begin
            if (h) m.halted = 1'b1;
            else   m.pc = t;
            m.instr = NOP; m.ipc = 8'h00; m.ipc1 = 8'h00; m.valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
            if (m.bcnt != 16'hFFFF) m.bcnt = m.bcnt + 16'd1;
`endif
        end else if (!s) begin
            m.instr = mem[m.pc];
            m.ipc   = m.pc;
            m.ipc1  = m.pc + 8'd1;
            m.valid = 1'b1;
            m.pc    = m.pc + 8'd1;
`ifdef FETCH_PERF_CNT_EN
            if (m.fcnt != 16'hFFFF) m.fcnt = m.fcnt + 16'd1;
`endif
        end
    endfunction

    task automatic cycle(input logic r, input logic s, input logic b,
                         input logic [7:0] t, input logic h);
        @(negedge clk);
        rst = r; stall = s; branch_taken = b; branch_target = t; halt_req = h;
        model_step(r, s, b, t, h);
        sbq.push_back(m);
    endtask

    task automatic normal(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that has a prediction queued is compared field by field.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("pc_out",        32'(pc_out),        32'(mon_e.pc));
            check("imem_addr",     32'(imem_addr),     32'(mon_e.pc));
            check("ifid_instr",    32'(ifid_instr),    32'(mon_e.instr));
            check("ifid_pc",       32'(ifid_pc),       32'(mon_e.ipc));
            check("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(mon_e.ipc1));
            check("ifid_valid",    32'(ifid_valid),    32'(mon_e.valid));
            check("halted",        32'(halted),        32'(mon_e.halted));
            check("fetch_count",   32'(fetch_count),   32'(mon_e.fcnt));
            check("bubble_count",  32'(bubble_count),  32'(mon_e.bcnt));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; halt_req = 1'b0;
        m = '{pc: 8'h00, instr: NOP, ipc: 8'h00, ipc1: 8'h00, valid: 1'b0,
              halted: 1'b0, fcnt: 16'h0, bcnt: 16'h0};
        for (int i = 0; i < 256; i++) mem[i] = INSTR_W'(8'h10 + i);

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        settle();
        check("reset_pc", 32'(pc_out), 32'(RESET_PC));
        check("reset_valid", 32'(ifid_valid), 32'(0));

        // Linear fetch to PC=5, then a 3-cycle stall
        normal(1);
        settle();
        check("first_fetch_instr", 32'(ifid_instr), 32'h10);
        normal(4);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        settle();
        check("stall_pc_hold", 32'(pc_out), 32'h05);
        check("stall_ifid_hold", 32'(ifid_pc), 32'h04);
        normal(1);

        // Branch overriding a simultaneous stall
        cycle(1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
        settle();
        check("branch_pc", 32'(pc_out), 32'h40);
        check("branch_bubble", 32'(ifid_valid), 32'(0));
        normal(1);
        settle();
        check("branch_target_instr", 32'(ifid_instr), 32'h50);
        check("branch_target_pc1", 32'(ifid_pc_plus1), 32'h41);

        // Counters: 6 fetches, 1 branch, 1 halt
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        normal(6);
        cycle(1'b0, 1'b0, 1'b1, 8'h20, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        settle();
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count_6", 32'(fetch_count), 32'd6);
        check("bubble_count_2", 32'(bubble_count), 32'd2);
`else
        check("fetch_count_off", 32'(fetch_count), 32'd0);
        check("bubble_count_off", 32'(bubble_count), 32'd0);
`endif

        // Halt at PC=9, then ignore branch/stall/halt for 10 cycles
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        normal(9);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'(i % 2), 8'($urandom), 1'($urandom_range(0, 1)));
        settle();
        check("halt_pc_hold", 32'(pc_out), 32'h09);
        check("halt_flag", 32'(halted), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
        settle();
        check("halt_exit_pc", 32'(pc_out), 32'(RESET_PC));
        check("halt_exit_flag", 32'(halted), 32'd0);

        // Wrap-around: 256 fetches from PC 0
        normal(256);
        settle();
        check("wrap_pc", 32'(pc_out), 32'h00);
        check("wrap_ifid_pc", 32'(ifid_pc), 32'hFF);
        check("wrap_ifid_pc1", 32'(ifid_pc_plus1), 32'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 256; i++) mem[i] = INSTR_W'($urandom);
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 59) == 0));

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
